// File: rtl/fifo_pkg.sv
// Shared helpers for thresh_fifo: width calculations and parameter-legality predicates.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 32'sd2;
  endfunction

  function automatic bit ae_thresh_ok(input int depth, input int ae);
    return (ae >= 32'sd0) && (ae <= depth - 32'sd1);
  endfunction

  function automatic bit af_thresh_ok(input int depth, input int af);
    return (af >= 32'sd1) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer, counts 0..DEPTH-1 for any DEPTH (including non-powers of two).
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Pointer register: clear has priority over increment, explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/thresh_fifo.sv
// First-word-fall-through FIFO with occupancy count and threshold flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module thresh_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AE_THRESH = DEPTH / 4,
  parameter int AF_THRESH = DEPTH - DEPTH / 4,
  localparam int CW = cnt_width(DEPTH),
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_val,
  output logic             data_in_rdy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_val,
  input  logic             data_out_rdy,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             ovf_err,
  output logic             unf_err
`endif
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("thresh_fifo: DEPTH must be >= 2");
  end
  if (!ae_thresh_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
    $error("thresh_fifo: AE_THRESH must be in 0..DEPTH-1");
  end
  if (!af_thresh_ok(DEPTH, AF_THRESH)) begin : g_bad_af
    $error("thresh_fifo: AF_THRESH must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Handshakes use only registered state, so data_out_rdy never reaches data_in_rdy.
  assign empty        = (count == CW'(0));
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign data_in_rdy  = !full;
  assign data_out_val = !empty;
  assign push         = data_in_val && data_in_rdy;
  assign pop          = data_out_val && data_out_rdy;
  assign wr_en        = push && !flush;
  assign data_out     = mem[rptr];

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (flush),
    .inc    (push),
    .ptr    (wptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (flush),
    .inc    (pop),
    .ptr    (rptr)
  );

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= data_in;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err || (data_in_val && full);
      unf_err <= unf_err || (data_out_rdy && empty);
    end
  end
`endif

endmodule

// File: tb/tb_thresh_fifo.sv
// Directed self-checking bench for thresh_fifo (WIDTH=8, DEPTH=6, AE=1, AF=5).
module tb_thresh_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [7:0] data_in;
  logic       data_in_val;
  logic       data_in_rdy;
  logic [7:0] data_out;
  logic       data_out_val;
  logic       data_out_rdy;
  logic [2:0] count;
  logic       empty;
  logic       almost_empty;
  logic       almost_full;
  logic       full;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf_err;
  logic       unf_err;
`endif

  int errors = 0;
  int checks = 0;

  thresh_fifo #(.WIDTH(8), .DEPTH(6), .AE_THRESH(1), .AF_THRESH(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .data_in     (data_in),
    .data_in_val (data_in_val),
    .data_in_rdy (data_in_rdy),
    .data_out    (data_out),
    .data_out_val(data_out_val),
    .data_out_rdy(data_out_rdy),
    .count       (count),
    .empty       (empty),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .full        (full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0; data_in_val = 1'b0; data_out_rdy = 1'b0; data_in = 8'h00;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push_val(input logic [7:0] v);
    data_in = v; data_in_val = 1'b1;
    step();
    data_in_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, empty, almost_empty, full, almost_full, data_in_rdy, data_out_val} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b ae=%b f=%b af=%b rdy=%b val=%b, expected cnt=0 e=1 ae=1 f=0 af=0 rdy=1 val=0",
               count, empty, almost_empty, full, almost_full, data_in_rdy, data_out_val);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (count !== 3'(i) || almost_full !== (i >= 5) || almost_empty !== (i <= 1) || full !== 1'b0 || data_in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL fill_step%0d: got cnt=%0d ae=%b af=%b f=%b rdy=%b, expected cnt=%0d ae=%b af=%b f=0 rdy=1",
                 i, count, almost_empty, almost_full, full, data_in_rdy, i, (i <= 1), (i >= 5));
      end
      data_in = 8'h10 + 8'(i); data_in_val = 1'b1;
      step();
    end
    checks++;
    if (count !== 3'd6 || full !== 1'b1 || data_in_rdy !== 1'b0 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d f=%b rdy=%b af=%b, expected cnt=6 f=1 rdy=0 af=1", count, full, data_in_rdy, almost_full);
    end
    data_in = 8'h16;
    step();
    data_in_val = 1'b0;
    checks++;
    if (count !== 3'd6 || data_out !== 8'h10) begin
      errors++;
      $display("FAIL fill_extra_push: got cnt=%0d head=%h, expected cnt=6 head=10", count, data_out);
    end
  endtask

  task automatic test_drain_wrap();
    data_out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (data_out !== 8'h10 + 8'(i) || data_out_val !== 1'b1 || count !== 3'(6 - i)) begin
        errors++;
        $display("FAIL drain_%0d: got data=%h val=%b cnt=%0d, expected data=%h val=1 cnt=%0d",
                 i, data_out, data_out_val, count, 8'h10 + 8'(i), 6 - i);
      end
      step();
    end
    data_out_rdy = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out_val !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got cnt=%0d e=%b val=%b ae=%b, expected cnt=0 e=1 val=0 ae=1", count, empty, data_out_val, almost_empty);
    end
    for (int k = 0; k < 7; k++) begin
      data_in = 8'hA0 + 8'(k); data_in_val = 1'b1;
      data_out_rdy = (k >= 2);
      if (k >= 2) begin
        checks++;
        if (data_out !== 8'hA0 + 8'(k - 2) || count !== 3'd2) begin
          errors++;
          $display("FAIL wrap_pop%0d: got data=%h cnt=%0d, expected data=%h cnt=2", k, data_out, count, 8'hA0 + 8'(k - 2));
        end
      end
      step();
    end
    data_in_val = 1'b0; data_out_rdy = 1'b1;
    for (int j = 5; j < 7; j++) begin
      checks++;
      if (data_out !== 8'hA0 + 8'(j)) begin
        errors++;
        $display("FAIL wrap_tail%0d: got data=%h, expected %h", j, data_out, 8'hA0 + 8'(j));
      end
      step();
    end
    data_out_rdy = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_empty: got e=%b cnt=%0d, expected e=1 cnt=0", empty, count);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 3; i++) push_val(8'hB0 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      data_in = 8'hB3 + 8'(i); data_in_val = 1'b1; data_out_rdy = 1'b1;
      checks++;
      if (count !== 3'd3 || data_out !== 8'hB0 + 8'(i) || {empty, almost_empty, almost_full, full} !== 4'b0000) begin
        errors++;
        $display("FAIL simul_%0d: got cnt=%0d data=%h flags=%b%b%b%b, expected cnt=3 data=%h flags=0000",
                 i, count, data_out, empty, almost_empty, almost_full, full, 8'hB0 + 8'(i));
      end
      step();
    end
    data_in_val = 1'b0; data_out_rdy = 1'b0;
    checks++;
    if (count !== 3'd3 || data_out !== 8'hBA) begin
      errors++;
      $display("FAIL simul_end: got cnt=%0d data=%h, expected cnt=3 data=ba", count, data_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) push_val(8'hC0 + 8'(i));
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d, expected 4", count);
    end
    flush = 1'b1; data_in = 8'hEE; data_in_val = 1'b1; data_out_rdy = 1'b1;
    step();
    flush = 1'b0; data_in_val = 1'b0; data_out_rdy = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out_val !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d e=%b val=%b, expected cnt=0 e=1 val=0", count, empty, data_out_val);
    end
    push_val(8'h55);
    push_val(8'h66);
    checks++;
    if (count !== 3'd2 || data_out !== 8'h55 || data_out_val !== 1'b1) begin
      errors++;
      $display("FAIL flush_next: got cnt=%0d data=%h val=%b, expected cnt=2 data=55 val=1", count, data_out, data_out_val);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push_val(8'hD0 + 8'(i));
    checks++;
    if (count !== 3'd5 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got cnt=%0d af=%b, expected cnt=5 af=1", count, almost_full);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, data_in_rdy, data_out_val} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_async: got cnt=%0d e=%b ae=%b f=%b af=%b rdy=%b val=%b, expected cnt=0 e=1 ae=1 f=0 af=0 rdy=1 val=0",
               count, empty, almost_empty, full, almost_full, data_in_rdy, data_out_val);
    end
    #2;
    reset_n = 1'b1;
    step();
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL areset_release: got e=%b cnt=%0d, expected e=1 cnt=0", empty, count);
    end
    push_val(8'h77);
    checks++;
    if (data_out !== 8'h77 || count !== 3'd1) begin
      errors++;
      $display("FAIL areset_first: got data=%h cnt=%0d, expected data=77 cnt=1", data_out, count);
    end
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    checks++;
    if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got ovf=%b unf=%b, expected 0 0", ovf_err, unf_err);
    end
    for (int i = 0; i < 6; i++) push_val(8'hE0 + 8'(i));
    checks++;
    if (ovf_err !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL err_full_noovf: got ovf=%b f=%b, expected ovf=0 f=1", ovf_err, full);
    end
    push_val(8'hEF);
    step();
    checks++;
    if (ovf_err !== 1'b1 || count !== 3'd6) begin
      errors++;
      $display("FAIL err_ovf_held: got ovf=%b cnt=%0d, expected ovf=1 cnt=6", ovf_err, count);
    end
    data_out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (unf_err !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL err_drain_nounf: got unf=%b cnt=%0d, expected unf=0 cnt=0", unf_err, count);
    end
    step();
    data_out_rdy = 1'b0;
    step();
    checks++;
    if (unf_err !== 1'b1 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL err_unf: got unf=%b ovf=%b, expected 1 1", unf_err, ovf_err);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (unf_err !== 1'b0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_flush: got unf=%b ovf=%b, expected 0 0", unf_err, ovf_err);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; flush = 1'b0; data_in = 8'h00; data_in_val = 1'b0; data_out_rdy = 1'b0;
    #3;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_flush();
    test_async_reset();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thresh_fifo.md
THRESH_FIFO -- requirements
Module: thresh_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, >= 2, any integer, not restricted to powers of two.
REQ-003 SHALL have parameter AE_THRESH, default DEPTH/4: almost-empty level, 0..DEPTH-1.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-DEPTH/4: almost-full level, 1..DEPTH.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1: synchronous discard of all contents.
REQ-008 SHALL have port data_in, input, WIDTH: write data.
REQ-009 SHALL have port data_in_val, input, 1: write request.
REQ-010 SHALL have port data_in_rdy, output, 1: write acceptance.
REQ-011 SHALL have port data_out, output, WIDTH: head-of-queue data.
REQ-012 SHALL have port data_out_val, output, 1: head valid.
REQ-013 SHALL have port data_out_rdy, input, 1: read request.
REQ-014 SHALL have port count, output, CW = $clog2(DEPTH+1): current occupancy.
REQ-015 SHALL have ports empty, almost_empty, almost_full and full, each output, 1: status flags.
REQ-016 SHALL have ports ovf_err and unf_err, each output, 1, present only under FIFO_ERR_FLAGS_EN: sticky error flags.

Function
REQ-017 SHALL accept a push when data_in_val && data_in_rdy, and a pop when data_out_val && data_out_rdy.
REQ-018 SHALL drive data_in_rdy = !full and data_out_val = !empty, with no combinational path from data_out_rdy to data_in_rdy.
REQ-019 SHALL be first-word-fall-through: data_out shows the oldest entry combinationally; a push into an empty FIFO is visible the next cycle.
REQ-020 SHALL advance the read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0 with no skipped or aliased entries for non-power-of-two DEPTH.
REQ-021 SHALL keep count as a register: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL derive all flags from count: empty = (count==0), full = (count==DEPTH), almost_empty = (count<=AE_THRESH), almost_full = (count>=AF_THRESH).
REQ-023 SHALL reject a push while full even if a pop occurs in the same cycle.
REQ-024 SHALL accept a simultaneous push and pop while not empty and not full, leaving count unchanged.
REQ-025 SHALL, on flush=1, zero the pointers and count at the next edge, discard any same-cycle push or pop, and leave memory contents unchanged.
REQ-026 SHALL leave data_out undefined (no specific value required) whenever data_out_val=0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force pointers=0 and count=0, giving empty=1, almost_empty=1, full=0, almost_full=0 (when AF_THRESH>0), data_in_rdy=1, data_out_val=0, ovf_err=0 and unf_err=0.
REQ-028 SHALL, on reset assertion mid-transfer, abandon all contents; the first push after deassertion is the first entry read.
REQ-029 SHALL not reset the storage array.

Configuration
REQ-030 SHALL, with macro FIFO_ERR_FLAGS_EN defined, set ovf_err on any cycle with data_in_val=1 while full and set unf_err on any cycle with data_out_rdy=1 while empty.
REQ-031 SHALL hold ovf_err and unf_err set until reset or flush.
REQ-032 SHALL, without FIFO_ERR_FLAGS_EN, omit both ports and their logic, with all other behaviour identical.

Structure
REQ-033 SHALL place count-width and pointer-width calculation functions and parameter-legality checks (elaboration-time assertions on AE_THRESH and AF_THRESH ranges) in shared package fifo_pkg.
REQ-034 SHALL implement each wrapping pointer as one instance of sub-module fifo_ptr (parameter DEPTH; inputs clk, reset_n, clr, inc; output ptr), used once for write and once for read.

Verification
REQ-035 SHALL cover fill to full: WIDTH=8, DEPTH=6, AE=1, AF=5; push 0x10..0x15 with no pops -> count reaches 6, almost_full=1 at count=5, full=1 and data_in_rdy=0 at count=6; a 7th push is ignored.
REQ-036 SHALL cover drain and wrap: from full, pop 6 times -> data 0x10..0x15 in order, empty=1 at count=0; then push 0xA0..0xA6 with pops interleaved -> in-order output across the pointer wrap at 5->0.
REQ-037 SHALL cover simultaneous push and pop: at count=3, hold push and pop for 10 cycles -> count stays 3, output order preserved, flags unchanged.
REQ-038 SHALL cover flush: at count=4, flush=1 together with a push -> next cycle count=0, empty=1; subsequent push 0x55 is read first.
REQ-039 SHALL cover asynchronous reset: assert reset_n=0 between clock edges at count=5 -> outputs reach reset values before the next edge; after release, empty=1.
REQ-040 SHALL cover error flags under FIFO_ERR_FLAGS_EN: push while full -> ovf_err=1 and held; pop while empty -> unf_err=1; flush -> both clear.
